// File: rtl/udt_rx_classifier.sv
// UDT receive classifier: splits the UDP receive stream into UDT data packets
// (header stripped, metadata attached) and single-record control packets, and
// drops and counts foreign-port, runt or rejected datagrams.
// Optional build macro: UDT_RX_SOCKID_FILTER_EN enables the destination
// socket ID filter in HDR1. When it is undefined, local_socket_id is unused.
//
// state    | meaning
// ---------+----------------------------------------------------------
// HDR0     | waiting for beat 0 (header words 0/1)
// HDR1     | waiting for beat 1 (timestamp / destination socket ID)
// DATA     | forwarding data payload through the output register
// CTRL_PL  | capturing the first control info beat, discarding the rest
// CTRL_OUT | presenting the control record until ctrl_ready
// DROP     | discarding the rest of a rejected datagram
module udt_rx_classifier #(
  parameter logic [15:0] PORT  = 16'd10086,
  parameter int          CNT_W = 16
) (
  input  logic             core_clk,
  input  logic             core_rst_n,
  input  logic             udp_rx_tvalid,
  output logic             udp_rx_tready,
  input  logic [63:0]      udp_rx_tdata,
  input  logic [7:0]       udp_rx_tkeep,
  input  logic             udp_rx_tlast,
  input  logic [31:0]      udp_rx_ip_src,
  input  logic [15:0]      udp_rx_port_src,
  input  logic [15:0]      udp_rx_port_dest,
  input  logic [31:0]      local_socket_id,
  output logic             data_tvalid,
  input  logic             data_tready,
  output logic [63:0]      data_tdata,
  output logic [7:0]       data_tkeep,
  output logic             data_tlast,
  output logic [30:0]      data_seq,
  output logic [31:0]      data_msgno,
  output logic [31:0]      data_peer_ip,
  output logic [15:0]      data_peer_port,
  output logic             ctrl_valid,
  input  logic             ctrl_ready,
  output logic [14:0]      ctrl_type,
  output logic [15:0]      ctrl_ext_type,
  output logic [31:0]      ctrl_add_info,
  output logic [31:0]      ctrl_timestamp,
  output logic [63:0]      ctrl_info,
  output logic             ctrl_info_vld,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] runt_cnt
);

  typedef enum logic [2:0] {
    HDR0     = 3'd0,
    HDR1     = 3'd1,
    DATA     = 3'd2,
    CTRL_PL  = 3'd3,
    CTRL_OUT = 3'd4,
    DROP     = 3'd5
  } state_e;

  state_e state_q, state_d;

  // Header latches for the packet currently being parsed.
  logic [31:0] word0_q, word1_q, word2_q, ip_q;
  logic [15:0] port_q;

  logic [63:0] info_q;
  logic        info_vld_q;

  // Data output register; sideband is reloaded only with a payload beat so a
  // new header can be absorbed while the previous final beat is still held.
  logic        out_vld_q, out_last_q;
  logic [63:0] out_data_q;
  logic [7:0]  out_keep_q;
  logic [30:0] out_seq_q;
  logic [31:0] out_msgno_q, out_ip_q;
  logic [15:0] out_port_q;

  logic [CNT_W-1:0] drop_q, runt_q;

  // Holds off upstream for the first cycle out of reset so tready is low
  // while reset is asserted.
  logic run_q;

  logic tready;
  logic hdr0_ld, hdr1_ld, out_ld, info_ld, info_clr, drop_inc, runt_inc;
  logic sid_reject;

`ifdef UDT_RX_SOCKID_FILTER_EN
  // Handshake control packets (type 0) arrive before the peer knows our ID.
  assign sid_reject = (local_socket_id != 32'd0)
                   && (udp_rx_tdata[31:0] != local_socket_id)
                   && !(word0_q[31] && (word0_q[30:16] == 15'd0));
`else
  logic unused_sockid;
  assign unused_sockid = ^local_socket_id;
  assign sid_reject    = 1'b0;
`endif

  // State register.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= HDR0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
    end
  end

  // Next-state decode, upstream ready and datapath load strobes.
  always_comb begin
    state_d  = state_q;
    tready   = 1'b0;
    hdr0_ld  = 1'b0;
    hdr1_ld  = 1'b0;
    out_ld   = 1'b0;
    info_ld  = 1'b0;
    info_clr = 1'b0;
    drop_inc = 1'b0;
    runt_inc = 1'b0;
    unique case (state_q)
      HDR0: begin
        tready = run_q;
        if (udp_rx_tvalid && run_q) begin
          if (udp_rx_port_dest != PORT) begin
            drop_inc = 1'b1;
            if (!udp_rx_tlast) state_d = DROP;
          end else begin
            hdr0_ld = 1'b1;
            if (udp_rx_tlast) runt_inc = 1'b1;
            else              state_d  = HDR1;
          end
        end
      end
      HDR1: begin
        tready = 1'b1;
        if (udp_rx_tvalid) begin
          hdr1_ld = 1'b1;
          if (sid_reject) begin
            drop_inc = 1'b1;
            state_d  = udp_rx_tlast ? HDR0 : DROP;
          end else if (!word0_q[31]) begin
            if (udp_rx_tlast) begin
              runt_inc = 1'b1;
              state_d  = HDR0;
            end else begin
              state_d = DATA;
            end
          end else begin
            info_clr = 1'b1;
            state_d  = udp_rx_tlast ? CTRL_OUT : CTRL_PL;
          end
        end
      end
      DATA: begin
        tready = !out_vld_q || data_tready;
        if (udp_rx_tvalid && tready) begin
          out_ld = 1'b1;
          if (udp_rx_tlast) state_d = HDR0;
        end
      end
      CTRL_PL: begin
        tready = 1'b1;
        if (udp_rx_tvalid) begin
          if (!info_vld_q)  info_ld = 1'b1;
          if (udp_rx_tlast) state_d = CTRL_OUT;
        end
      end
      CTRL_OUT: begin
        if (ctrl_ready) state_d = HDR0;
      end
      DROP: begin
        tready = 1'b1;
        if (udp_rx_tvalid && udp_rx_tlast) state_d = HDR0;
      end
      default: state_d = HDR0;
    endcase
  end

  // Header latches, control info capture, data output register and counters.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      word0_q     <= '0;
      word1_q     <= '0;
      word2_q     <= '0;
      ip_q        <= '0;
      port_q      <= '0;
      info_q      <= '0;
      info_vld_q  <= 1'b0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_seq_q   <= '0;
      out_msgno_q <= '0;
      out_ip_q    <= '0;
      out_port_q  <= '0;
      drop_q      <= '0;
      runt_q      <= '0;
    end else begin
      if (hdr0_ld) begin
        word0_q <= udp_rx_tdata[63:32];
        word1_q <= udp_rx_tdata[31:0];
        ip_q    <= udp_rx_ip_src;
        port_q  <= udp_rx_port_src;
      end
      if (hdr1_ld) word2_q <= udp_rx_tdata[63:32];
      if (info_clr) begin
        info_q     <= '0;
        info_vld_q <= 1'b0;
      end else if (info_ld) begin
        info_q     <= udp_rx_tdata;
        info_vld_q <= 1'b1;
      end
      if (out_ld) begin
        out_vld_q   <= 1'b1;
        out_data_q  <= udp_rx_tdata;
        out_keep_q  <= udp_rx_tkeep;
        out_last_q  <= udp_rx_tlast;
        out_seq_q   <= word0_q[30:0];
        out_msgno_q <= word1_q;
        out_ip_q    <= ip_q;
        out_port_q  <= port_q;
      end else if (data_tready) begin
        out_vld_q <= 1'b0;
      end
      if (drop_inc && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      if (runt_inc && (runt_q != '1)) runt_q <= runt_q + 1'b1;
    end
  end

  assign udp_rx_tready  = tready;
  assign data_tvalid    = out_vld_q;
  assign data_tdata     = out_data_q;
  assign data_tkeep     = out_keep_q;
  assign data_tlast     = out_last_q;
  assign data_seq       = out_seq_q;
  assign data_msgno     = out_msgno_q;
  assign data_peer_ip   = out_ip_q;
  assign data_peer_port = out_port_q;
  assign ctrl_valid     = (state_q == CTRL_OUT);
  assign ctrl_type      = word0_q[30:16];
  assign ctrl_ext_type  = word0_q[15:0];
  assign ctrl_add_info  = word1_q;
  assign ctrl_timestamp = word2_q;
  assign ctrl_info      = info_q;
  assign ctrl_info_vld  = info_vld_q;
  assign drop_cnt       = drop_q;
  assign runt_cnt       = runt_q;

endmodule

// File: tb/tb_udt_rx_classifier.sv
// Testbench for udt_rx_classifier: directed and randomized datagrams checked
// against a packet-level reference model (expected beat/record queues and
// counter values derived from the datagram contents).
module tb_udt_rx_classifier;

  logic        core_clk = 1'b0;
  logic        core_rst_n;
  logic        udp_rx_tvalid, udp_rx_tready, udp_rx_tlast;
  logic [63:0] udp_rx_tdata;
  logic [7:0]  udp_rx_tkeep;
  logic [31:0] udp_rx_ip_src, local_socket_id;
  logic [15:0] udp_rx_port_src, udp_rx_port_dest;
  logic        data_tvalid, data_tready, data_tlast;
  logic [63:0] data_tdata;
  logic [7:0]  data_tkeep;
  logic [30:0] data_seq;
  logic [31:0] data_msgno, data_peer_ip;
  logic [15:0] data_peer_port;
  logic        ctrl_valid, ctrl_ready, ctrl_info_vld;
  logic [14:0] ctrl_type;
  logic [15:0] ctrl_ext_type;
  logic [31:0] ctrl_add_info, ctrl_timestamp;
  logic [63:0] ctrl_info;
  logic [15:0] drop_cnt, runt_cnt;

  udt_rx_classifier dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .udp_rx_tvalid(udp_rx_tvalid), .udp_rx_tready(udp_rx_tready),
    .udp_rx_tdata(udp_rx_tdata), .udp_rx_tkeep(udp_rx_tkeep),
    .udp_rx_tlast(udp_rx_tlast), .udp_rx_ip_src(udp_rx_ip_src),
    .udp_rx_port_src(udp_rx_port_src), .udp_rx_port_dest(udp_rx_port_dest),
    .local_socket_id(local_socket_id),
    .data_tvalid(data_tvalid), .data_tready(data_tready),
    .data_tdata(data_tdata), .data_tkeep(data_tkeep), .data_tlast(data_tlast),
    .data_seq(data_seq), .data_msgno(data_msgno),
    .data_peer_ip(data_peer_ip), .data_peer_port(data_peer_port),
    .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
    .ctrl_type(ctrl_type), .ctrl_ext_type(ctrl_ext_type),
    .ctrl_add_info(ctrl_add_info), .ctrl_timestamp(ctrl_timestamp),
    .ctrl_info(ctrl_info), .ctrl_info_vld(ctrl_info_vld),
    .drop_cnt(drop_cnt), .runt_cnt(runt_cnt)
  );

  always #5 core_clk = ~core_clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [30:0] seq;
    logic [31:0] msg;
    logic [31:0] ip;
    logic [15:0] port;
  } dbeat_t;

  typedef struct packed {
    logic [14:0] t;
    logic [15:0] et;
    logic [31:0] ai;
    logic [31:0] ts;
    logic [63:0] info;
    logic        iv;
  } crec_t;

  dbeat_t      exp_d[$];
  crec_t       exp_c[$];
  logic [63:0] dg_q[$];
  logic [7:0]  kp_q[$];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] drop_m = '0;
  logic [15:0] runt_m = '0;
  int          dmode = 0;
  int          cmode = 0;
  int          cyc = 0;
  bit          last_hs;
  logic        lat_tv;
  logic [63:0] lat_td;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // One clock: check outputs at the falling edge, then step past the rising edge.
  task automatic tick();
    dbeat_t e;
    crec_t  c;
    @(negedge core_clk);
    if (data_tvalid) begin
      if (exp_d.size() == 0) begin
        chk("data_unexpected", 64'(data_tvalid), 64'd0);
      end else begin
        e = exp_d[0];
        chk("data_tdata", data_tdata, e.d);
        chk("data_tkeep", 64'(data_tkeep), 64'(e.k));
        chk("data_tlast", 64'(data_tlast), 64'(e.l));
        chk("data_seq", 64'(data_seq), 64'(e.seq));
        chk("data_msgno", 64'(data_msgno), 64'(e.msg));
        chk("data_peer_ip", 64'(data_peer_ip), 64'(e.ip));
        chk("data_peer_port", 64'(data_peer_port), 64'(e.port));
        if (data_tready) void'(exp_d.pop_front());
      end
    end
    if (ctrl_valid) begin
      if (exp_c.size() == 0) begin
        chk("ctrl_unexpected", 64'(ctrl_valid), 64'd0);
      end else begin
        c = exp_c[0];
        chk("ctrl_type", 64'(ctrl_type), 64'(c.t));
        chk("ctrl_ext_type", 64'(ctrl_ext_type), 64'(c.et));
        chk("ctrl_add_info", 64'(ctrl_add_info), 64'(c.ai));
        chk("ctrl_timestamp", 64'(ctrl_timestamp), 64'(c.ts));
        chk("ctrl_info", ctrl_info, c.info);
        chk("ctrl_info_vld", 64'(ctrl_info_vld), 64'(c.iv));
        if (ctrl_ready) void'(exp_c.pop_front());
      end
    end
    last_hs = udp_rx_tvalid && udp_rx_tready;
    @(posedge core_clk);
    #1;
    cyc++;
    case (dmode)
      0:       data_tready = 1'b1;
      1:       data_tready = ~data_tready;
      default: data_tready = 1'($urandom_range(1));
    endcase
    case (cmode)
      0:       ctrl_ready = 1'b1;
      1:       ctrl_ready = ctrl_ready;
      default: ctrl_ready = 1'($urandom_range(1));
    endcase
  endtask

  task automatic build(input logic [31:0] w0, input logic [31:0] w1,
                       input logic [31:0] w2, input logic [31:0] w3, input int nb);
    dg_q.delete();
    kp_q.delete();
    dg_q.push_back({w0, w1});
    kp_q.push_back(8'hFF);
    if (nb >= 2) begin
      dg_q.push_back({w2, w3});
      kp_q.push_back(8'hFF);
    end
    for (int i = 2; i < nb; i++) begin
      dg_q.push_back({$urandom, $urandom});
      kp_q.push_back(8'($urandom));
    end
  endtask

  // Packet-level outcome of the datagram held in dg_q.
  task automatic model(input logic [15:0] pdest, input logic [31:0] ip, input logic [15:0] psrc);
    int          n;
    logic [63:0] b0, b1;
    bit          rej;
    dbeat_t      e;
    crec_t       c;
    n  = dg_q.size();
    b0 = dg_q[0];
    if (pdest != 16'd10086) begin
      drop_m = sat(drop_m);
    end else if (n < 2) begin
      runt_m = sat(runt_m);
    end else begin
      b1  = dg_q[1];
      rej = 1'b0;
`ifdef UDT_RX_SOCKID_FILTER_EN
      rej = (local_socket_id != 32'd0) && (b1[31:0] != local_socket_id)
         && !(b0[63] && (b0[62:48] == 15'd0));
`endif
      if (rej) begin
        drop_m = sat(drop_m);
      end else if (!b0[63]) begin
        if (n == 2) begin
          runt_m = sat(runt_m);
        end else begin
          for (int i = 2; i < n; i++) begin
            e.d    = dg_q[i];
            e.k    = kp_q[i];
            e.l    = (i == n - 1);
            e.seq  = b0[62:32];
            e.msg  = b0[31:0];
            e.ip   = ip;
            e.port = psrc;
            exp_d.push_back(e);
          end
        end
      end else begin
        c.t    = b0[62:48];
        c.et   = b0[47:32];
        c.ai   = b0[31:0];
        c.ts   = b1[63:32];
        c.info = (n > 2) ? dg_q[2] : 64'd0;
        c.iv   = (n > 2);
        exp_c.push_back(c);
      end
    end
  endtask

  task automatic send_dgram(input logic [15:0] pdest, input logic [31:0] ip,
                            input logic [15:0] psrc, input int gap);
    int n;
    int w;
    model(pdest, ip, psrc);
    n = dg_q.size();
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (gap > 0 && w < 2 && int'($urandom_range(99)) < gap) begin
        udp_rx_tvalid = 1'b0;
        tick();
        w++;
      end
      udp_rx_tvalid    = 1'b1;
      udp_rx_tdata     = dg_q[i];
      udp_rx_tkeep     = kp_q[i];
      udp_rx_tlast     = (i == n - 1);
      udp_rx_ip_src    = ip;
      udp_rx_port_src  = psrc;
      udp_rx_port_dest = pdest;
      w = 0;
      do begin
        tick();
        w++;
      end while (!last_hs && w < 200);
      chk("beat_accept", 64'(last_hs), 64'd1);
      if (i == 2) begin
        lat_tv = data_tvalid;
        lat_td = data_tdata;
      end
      if (!last_hs) break;
    end
    udp_rx_tvalid = 1'b0;
    udp_rx_tlast  = 1'b0;
    chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
    chk("runt_cnt", 64'(runt_cnt), 64'(runt_m));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while ((exp_d.size() != 0 || exp_c.size() != 0) && w < 200) begin
      tick();
      w++;
    end
    tick();
    chk("drain_data", 64'(exp_d.size()), 64'd0);
    chk("drain_ctrl", 64'(exp_c.size()), 64'd0);
  endtask

  initial begin
    int          kind;
    int          nb;
    logic [31:0] w0;
    logic [15:0] pd;

    core_rst_n       = 1'b0;
    udp_rx_tvalid    = 1'b0;
    udp_rx_tdata     = '0;
    udp_rx_tkeep     = '0;
    udp_rx_tlast     = 1'b0;
    udp_rx_ip_src    = '0;
    udp_rx_port_src  = '0;
    udp_rx_port_dest = '0;
    local_socket_id  = '0;
    data_tready      = 1'b1;
    ctrl_ready       = 1'b1;
    #2;
    chk("rst_tready", 64'(udp_rx_tready), 64'd0);
    chk("rst_data_tvalid", 64'(data_tvalid), 64'd0);
    chk("rst_ctrl_valid", 64'(ctrl_valid), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_runt_cnt", 64'(runt_cnt), 64'd0);
    chk("rst_data_seq", 64'(data_seq), 64'd0);
    chk("rst_ctrl_info", ctrl_info, 64'd0);
    repeat (3) @(posedge core_clk);
    #1;
    core_rst_n = 1'b1;
    tick();
    tick();

    // Basic data packet: seq 5, msgno C0000001, 3 payload beats.
    build(32'h0000_0005, 32'hC000_0001, 32'h1234_5678, 32'h0000_0007, 5);
    send_dgram(16'd10086, 32'h0A00_0001, 16'd9000, 0);
    chk("latency_tvalid", 64'(lat_tv), 64'd1);
    chk("latency_tdata", lat_td, dg_q[2]);
    drain();
    chk("held_seq", 64'(data_seq), 64'd5);
    chk("held_msgno", 64'(data_msgno), 64'hC000_0001);

    // Control ACK with one info beat and a discarded second beat; hold ctrl_ready low.
    cmode      = 1;
    ctrl_ready = 1'b0;
    build(32'h8002_0000, 32'h0000_00AA, 32'h0000_1111, 32'h0000_0007, 4);
    dg_q[2] = 64'h11;
    send_dgram(16'd10086, 32'h0A00_0002, 16'd9001, 0);
    repeat (3) begin
      tick();
      chk("ctrl_hold_valid", 64'(ctrl_valid), 64'd1);
      chk("ctrl_hold_tready", 64'(udp_rx_tready), 64'd0);
    end
    chk("ack_type", 64'(ctrl_type), 64'd2);
    chk("ack_info", ctrl_info, 64'h11);
    chk("ack_info_vld", 64'(ctrl_info_vld), 64'd1);
    ctrl_ready = 1'b1;
    tick();
    chk("ack_released", 64'(ctrl_valid), 64'd0);
    cmode = 0;
    drain();

    // Control without payload: info must read as absent.
    build(32'h8006_0003, 32'h0000_0001, 32'h0000_2222, 32'h0000_0007, 2);
    send_dgram(16'd10086, 32'h0A00_0003, 16'd9002, 0);
    drain();

    // Foreign destination port.
    build(32'h0000_0009, 32'h1, 32'h2, 32'h3, 4);
    send_dgram(16'd5000, 32'h0A00_0004, 16'd9003, 0);
    chk("port_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("port_no_data", 64'(data_tvalid), 64'd0);
    chk("port_no_ctrl", 64'(ctrl_valid), 64'd0);
    drain();

    // Runts: data header ending on beat 1, then on beat 0, then a good packet.
    build(32'h0000_0011, 32'h2, 32'h3, 32'h4, 2);
    send_dgram(16'd10086, 32'h0A00_0005, 16'd9004, 0);
    chk("runt_cnt_one", 64'(runt_cnt), 64'd1);
    chk("runt_no_data", 64'(data_tvalid), 64'd0);
    build(32'h0000_0012, 32'h2, 32'h3, 32'h4, 1);
    send_dgram(16'd10086, 32'h0A00_0005, 16'd9004, 0);
    build(32'h0000_0013, 32'h5, 32'h6, 32'h7, 4);
    send_dgram(16'd10086, 32'h0A00_0006, 16'd9005, 0);
    drain();

    // Downstream toggling with a back-to-back following packet.
    dmode = 1;
    build(32'h0000_0100, 32'h4000_0002, 32'h9, 32'h7, 8);
    send_dgram(16'd10086, 32'h0A00_0007, 16'd9006, 0);
    build(32'h0000_0101, 32'h4000_0003, 32'hA, 32'h7, 4);
    send_dgram(16'd10086, 32'h0A00_0008, 16'd9007, 0);
    drain();
    dmode = 0;

`ifdef UDT_RX_SOCKID_FILTER_EN
    local_socket_id = 32'd7;
    build(32'h0000_0200, 32'h1, 32'h2, 32'd8, 4);
    send_dgram(16'd10086, 32'h0A00_0009, 16'd9008, 0);
    build(32'h8000_0000, 32'h1, 32'h2, 32'd8, 3);
    send_dgram(16'd10086, 32'h0A00_0009, 16'd9008, 0);
    drain();
    local_socket_id = 32'd0;
`endif

    // Randomized mix of data, control, foreign and short datagrams.
    dmode = 2;
    cmode = 2;
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(3));
      nb   = int'($urandom_range(1, 6));
      w0   = $urandom;
      pd   = 16'd10086;
      case (kind)
        0:       w0[31] = 1'b0;
        1:       w0[31] = 1'b1;
        2:       pd = 16'd10087 + 16'($urandom_range(100));
        default: ;
      endcase
      build(w0, $urandom, $urandom, $urandom, nb);
      send_dgram(pd, $urandom, 16'($urandom), 30);
    end
    drain();
    dmode = 0;
    cmode = 0;

    // Drop counter saturation.
    build(32'h0, 32'h0, 32'h0, 32'h0, 1);
    for (int i = 0; i < 65540; i++) begin
      send_dgram(16'd4000, 32'h0A00_00FF, 16'd1, 0);
    end
    chk("drop_saturated", 64'(drop_cnt), 64'hFFFF);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udt_rx_classifier.md
Name: udt_rx_classifier

Overview:
Sits between the UDP receive stream (udp_rx_*) and the UDT core. Parses the 16-byte UDT header from the first two 64-bit beats of each UDP datagram. Data packets go to the core with the header stripped and sequence/message metadata attached. Control packets are reduced to a single header-plus-first-info record; foreign-port and malformed datagrams are dropped and counted.

Parameters:
PORT, 16'd10086, UDP destination port accepted; any other port is dropped.
CNT_W, 16, width of the saturating drop/runt counters.

Ports:
core_clk  in  1  core clock
core_rst_n  in  1  asynchronous active-low reset
udp_rx_tvalid  in  1  UDP payload beat valid
udp_rx_tready  out  1  UDP payload beat ready
udp_rx_tdata  in  64  payload; byte 0 on wire = [63:56]
udp_rx_tkeep  in  8  byte enables, MSB-first packing
udp_rx_tlast  in  1  last beat of datagram
udp_rx_ip_src  in  32  peer IP, sampled on beat 0
udp_rx_port_src  in  16  peer port, sampled on beat 0
udp_rx_port_dest  in  16  destination port, sampled on beat 0
local_socket_id  in  32  local UDT socket ID (optional feature only)
data_tvalid  out  1  data payload beat valid
data_tready  in  1  data payload beat ready
data_tdata  out  64  payload beat
data_tkeep  out  8  payload byte enables
data_tlast  out  1  last payload beat
data_seq  out  31  sequence number, stable for whole packet
data_msgno  out  32  message word (header word 1), stable for whole packet
data_peer_ip  out  32  source IP of current packet
data_peer_port  out  16  source port of current packet
ctrl_valid  out  1  control record valid
ctrl_ready  in  1  control record accepted
ctrl_type  out  15  header word0[30:16]
ctrl_ext_type  out  16  header word0[15:0]
ctrl_add_info  out  32  header word1
ctrl_timestamp  out  32  header word2
ctrl_info  out  64  first control payload beat, 0 if absent
ctrl_info_vld  out  1  ctrl_info present
drop_cnt  out  CNT_W  saturating count of dropped datagrams
runt_cnt  out  CNT_W  saturating count of runt datagrams

Behaviour:
- Reset: all outputs 0; udp_rx_tready 0; state HDR0; counters 0.
- Header words: beat0 [63:32]=word0, [31:0]=word1; beat1 [63:32]=word2 (timestamp), [31:0]=word3 (dest socket ID). word0[31]: 0=data, 1=control.
- States: HDR0, HDR1, DATA, CTRL_PL, CTRL_OUT, DROP.
- HDR0: tready=1. On a beat:
  - port_dest != PORT -> DROP; drop_cnt+1.
  - Else latch word0/1, ip_src, port_src -> HDR1.
  - If tlast is set, and the port matched -> runt; runt_cnt+1; stay HDR0.
- HDR1: tready=1. On a beat, latch word2/3.
  - tlast with a data flag -> runt; runt_cnt+1; back to HDR0 (zero-payload data is illegal).
  - tlast with a control flag -> ctrl_info=0, ctrl_info_vld=0 -> CTRL_OUT.
  - Otherwise data -> DATA; control -> CTRL_PL.
- DATA: single registered output stage.
  - udp_rx_tready = !data_tvalid || data_tready; each accepted beat is loaded into data_* on the next cycle.
  - data_seq = word0[30:0]; data_msgno, data_peer_ip and data_peer_port are held until data_tlast is accepted downstream.
  - Return to HDR0 when the tlast beat is accepted from upstream.
  - The next header may be absorbed while the output stage still holds the final beat; the data_* sideband must not change before that beat is accepted.
- CTRL_PL: tready=1.
  - First beat -> ctrl_info, ctrl_info_vld=1.
  - Later beats are discarded.
  - On tlast -> CTRL_OUT.
- CTRL_OUT: tready=0; ctrl_valid=1 with all fields stable; on ctrl_ready -> ctrl_valid=0, HDR0. Single-cycle acceptance is allowed.
- DROP: tready=1; discard beats; on tlast -> HDR0.
- Counters saturate at all-ones; no wrap.
- tkeep is passed through unmodified in DATA and ignored elsewhere.
- Reset mid-packet: state returns to HDR0 and the output stage is cleared. The remainder of an interrupted upstream datagram is parsed as a new header; upstream must also be reset.
- Timing: latency beat to data_tvalid = 1 cycle. Header overhead = 2 beats per datagram with no added bubbles in the data path.

Optional Feature:
UDT_RX_SOCKID_FILTER_EN.
- Defined: in HDR1, word3 != local_socket_id, with local_socket_id != 0 -> DROP; drop_cnt+1. When tlast is on that beat -> HDR0, counted as drop. Control packets with word0[30:16]==0 (handshake) are exempt.
- Undefined: word3 is ignored and the local_socket_id port is unused.

Test Plan:
- Data: port 10086, beats {32'h0000_0005, 32'hC000_0001}, {ts, sid}, payload 3 beats, tlast on beat 3, data_tready=1 -> 3 data beats, data_seq=5, data_msgno=32'hC0000001, tlast on the 3rd beat, one cycle of latency.
- Control ACK: word0=32'h8002_0000, with one info beat 64'h11 and a 2nd discarded beat -> ctrl_valid with type=2, ctrl_info=64'h11, ctrl_info_vld=1; tready held low until ctrl_ready.
- Port filter: port_dest=5000, 4-beat datagram -> no outputs, drop_cnt=1, all beats accepted.
- Runt: data header with tlast on beat 1 -> runt_cnt=1, no data_tvalid; a following valid packet is parsed normally.
- Backpressure: data_tready toggling 1010 during a 6-beat payload -> no beat lost or duplicated, sideband stable, back-to-back next header absorbed correctly.
- Saturation and feature: force 65536 drops -> drop_cnt=16'hFFFF. With UDT_RX_SOCKID_FILTER_EN defined and local_socket_id=7, a data packet with sid=8 is dropped and a handshake control packet with sid=8 is delivered.
